// File: rtl/acq_pkg.sv
// Shared types, default widths and helpers for the acquisition run controller.
package acq_pkg;

    localparam int DEF_FLUSH_CYCLES   = 16;
    localparam int DEF_SETTLE_SAMPLES = 64;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_WARMUP  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } acq_state_t;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/acq_counter.sv
// Loadable down-counter shared by the flush, warm-up and capture phases.
// tc_o flags that the next decrement is the last one of the loaded span.
module acq_counter
    import acq_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LEN_W'(1));

endmodule

// File: rtl/acq_sequencer.sv
// Run controller between the signal chain and the framer: flush, warm-up discard,
// bounded/continuous capture with one-cycle forwarding and backpressure drop counting.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int LEN_W          = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LEN_W-1:0]  capture_len_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              busy_i,
    output logic              chain_en_o,
    output logic              chain_flush_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              running_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [LEN_W-1:0]  drop_cnt_o,
    output logic              overrun_o
);

    localparam logic [LEN_W-1:0] FLUSH_LOAD  = LEN_W'(FLUSH_CYCLES);
    localparam logic [LEN_W-1:0] SETTLE_LOAD = LEN_W'(SETTLE_SAMPLES);

    acq_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              aborted_q, aborted_d;
    logic [LEN_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              overrun_q, overrun_d;

    logic              cnt_load;
    logic [LEN_W-1:0]  cnt_val;
    logic              cnt_dec;
    logic              cnt_tc;

    acq_counter #(
        .LEN_W (LEN_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        aborted_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        overrun_d  = overrun_q;
        cnt_load   = 1'b0;
        cnt_val    = FLUSH_LOAD;
        cnt_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d    = ST_FLUSH;
                    len_d      = capture_len_i;
                    drop_cnt_d = '0;
                    overrun_d  = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_val    = FLUSH_LOAD;
                end
            end

            ST_FLUSH: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_tc) begin
                        cnt_load = 1'b1;
                        // With no warm-up to discard, capture starts straight after the flush.
                        if (SETTLE_SAMPLES == 0) begin
                            state_d = ST_CAPTURE;
                            cnt_val = len_q;
                        end else begin
                            state_d = ST_WARMUP;
                            cnt_val = SETTLE_LOAD;
                        end
                    end
                end
            end

            ST_WARMUP: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (valid_i) begin
                    cnt_dec = 1'b1;
                    if (cnt_tc) begin
                        state_d  = ST_CAPTURE;
                        cnt_load = 1'b1;
                        cnt_val  = len_q;
                    end
                end
            end

            ST_CAPTURE: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (valid_i) begin
                    if (busy_i) begin
                        drop_cnt_d = LEN_W'(sat_inc(32'(drop_cnt_q), LEN_W));
                        overrun_d  = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = data_i;
                    end
                    // A zero length means continuous: the counter is left alone so it never terminates.
                    if (len_q != '0) begin
                        cnt_dec = 1'b1;
                        if (cnt_tc) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            aborted_q  <= 1'b0;
            drop_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            aborted_q  <= aborted_d;
            drop_cnt_q <= drop_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign chain_flush_o = (state_q == ST_FLUSH);
    assign chain_en_o    = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);
    assign running_o     = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign valid_o       = valid_q;
    assign data_o        = data_q;
    assign aborted_o     = aborted_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: directed scenarios plus random traffic, checked each cycle
// against a run-level reference model (strobe index arithmetic, not state encoding).
module tb_acq_sequencer;

    localparam int F  = 4;
    localparam int S  = 3;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          abort_i;
    logic [LW-1:0] capture_len_i;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          busy_i;
    logic          chain_en_o;
    logic          chain_flush_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          running_o;
    logic          done_o;
    logic          aborted_o;
    logic [LW-1:0] drop_cnt_o;
    logic          overrun_o;

    acq_sequencer #(
        .FLUSH_CYCLES   (F),
        .SETTLE_SAMPLES (S),
        .DATA_W         (DW),
        .LEN_W          (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .capture_len_i (capture_len_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .busy_i        (busy_i),
        .chain_en_o    (chain_en_o),
        .chain_flush_o (chain_flush_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .running_o     (running_o),
        .done_o        (done_o),
        .aborted_o     (aborted_o),
        .drop_cnt_o    (drop_cnt_o),
        .overrun_o     (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is tracked by cycles since acceptance and enabled-strobe index.
    bit          m_active;
    bit          m_done;
    int          m_cyc;
    int          m_k;
    int          m_len;
    int          m_drop;
    bit          m_ovr;
    logic [DW-1:0] m_data;
    bit          e_valid;
    bit          e_aborted;

    int n_valid, n_done, n_abort, n_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int idx;
        e_valid   = 1'b0;
        e_aborted = 1'b0;
        if (!rst) begin
            m_active = 1'b0; m_done = 1'b0; m_cyc = 0; m_k = 0;
            m_drop = 0; m_ovr = 1'b0; m_data = '0;
        end else if (!m_active) begin
            if (start_i && !abort_i) begin
                m_active = 1'b1; m_done = 1'b0; m_cyc = 1; m_k = 0;
                m_len = int'(capture_len_i); m_drop = 0; m_ovr = 1'b0;
            end
        end else if (m_done) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (abort_i) begin
            m_active  = 1'b0;
            e_aborted = 1'b1;
        end else begin
            if (m_cyc > F && valid_i) begin
                m_k++;
                if (m_k > S) begin
                    idx = m_k - S;
                    if (busy_i) begin
                        if (m_drop < 65535) m_drop++;
                        m_ovr = 1'b1;
                    end else begin
                        e_valid = 1'b1;
                        m_data  = data_i;
                    end
                    if (m_len != 0 && idx == m_len) m_done = 1'b1;
                end
            end
            m_cyc++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("running",  64'(running_o),     64'(m_active));
        chk("flush",    64'(chain_flush_o), 64'(m_active && !m_done && m_cyc <= F));
        chk("chain_en", 64'(chain_en_o),    64'(m_active && !m_done && m_cyc > F));
        chk("done",     64'(done_o),        64'(m_active && m_done));
        chk("valid",    64'(valid_o),       64'(e_valid));
        chk("data",     64'(data_o),        64'(m_data));
        chk("aborted",  64'(aborted_o),     64'(e_aborted));
        chk("drop_cnt", 64'(drop_cnt_o),    64'(m_drop));
        chk("overrun",  64'(overrun_o),     64'(m_ovr));
        if (valid_o)       n_valid++;
        if (done_o)        n_done++;
        if (aborted_o)     n_abort++;
        if (chain_flush_o) n_flush++;
    endtask

    task automatic drive(input bit s, input bit a, input bit v, input bit b);
        start_i = s;
        abort_i = a;
        valid_i = v;
        busy_i  = b;
        data_i  = $urandom;
        tick();
    endtask

    function automatic int next_idx();
        return (m_active && !m_done && m_cyc > F) ? (m_k + 1 - S) : -99;
    endfunction

    task automatic clear_counts();
        n_valid = 0; n_done = 0; n_abort = 0; n_flush = 0;
    endtask

    initial begin
        bit v, b, a, s;
        rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0; busy_i = 1'b0;
        capture_len_i = '0; data_i = '0;
        m_active = 1'b0; m_done = 1'b0; m_cyc = 0; m_k = 0; m_len = 0;
        m_drop = 0; m_ovr = 1'b0; m_data = '0; e_valid = 1'b0; e_aborted = 1'b0;
        clear_counts();

        // Reset state
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        chk("reset_data", 64'(data_o), 64'd0);
        rst = 1'b1;
        drive(0, 0, 0, 0);

        // Bounded run, len=5, strobe every 4 cycles, no backpressure
        clear_counts();
        capture_len_i = 16'd5;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 300 && n_done == 0; i++) drive(0, 0, (i % 4) == 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s1_flush_cycles", 64'(n_flush), 64'd4);
        chk("s1_valid_count",  64'(n_valid), 64'd5);
        chk("s1_done_count",   64'(n_done),  64'd1);
        chk("s1_drop_cnt",     64'(drop_cnt_o), 64'd0);

        // Backpressure on capture strobes 2 and 5, len=8
        clear_counts();
        capture_len_i = 16'd8;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 400 && n_done == 0; i++) begin
            v = 1'($urandom_range(0, 1));
            b = v && ((next_idx() <= 0) ? 1'($urandom_range(0, 1))
                                        : (next_idx() == 2 || next_idx() == 5));
            drive(0, 0, v, b);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s2_valid_count", 64'(n_valid),    64'd6);
        chk("s2_drop_cnt",    64'(drop_cnt_o), 64'd2);
        chk("s2_overrun",     64'(overrun_o),  64'd1);
        chk("s2_done_count",  64'(n_done),     64'd1);

        // Continuous run: 100 captured strobes, then abort
        clear_counts();
        capture_len_i = 16'd0;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 2000 && !(m_active && (m_k - S) >= 100); i++)
            drive(0, 0, 1'($urandom_range(0, 1)), 0);
        drive(0, 1, 0, 0);
        chk("s3_chain_en_after_abort", 64'(chain_en_o), 64'd0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s3_valid_count", 64'(n_valid), 64'd100);
        chk("s3_abort_count", 64'(n_abort), 64'd1);
        chk("s3_done_count",  64'(n_done),  64'd0);

        // Abort coincident with the final sample of a len=4 run
        clear_counts();
        capture_len_i = 16'd4;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v && next_idx() == 4) begin
                drive(0, 1, 1, 0);
                break;
            end
            drive(0, 0, v, 0);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s4_valid_count", 64'(n_valid), 64'd3);
        chk("s4_abort_count", 64'(n_abort), 64'd1);
        chk("s4_done_count",  64'(n_done),  64'd0);

        // start_i during capture with a different length is ignored
        clear_counts();
        capture_len_i = 16'd6;
        drive(1, 0, 0, 0);
        capture_len_i = 16'd2;
        for (int i = 0; i < 400 && n_done == 0; i++) begin
            s = m_active && !m_done && (m_k - S) == 2;
            drive(s, 0, 1'($urandom_range(0, 1)), 0);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s5_valid_count", 64'(n_valid), 64'd6);
        chk("s5_done_count",  64'(n_done),  64'd1);
        capture_len_i = 16'd5;
        drive(1, 1, 0, 0);
        chk("s5_start_abort_idle", 64'(running_o), 64'd0);
        drive(0, 0, 0, 0);

        // Reset in the middle of warm-up, then a fresh full run
        clear_counts();
        capture_len_i = 16'd3;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 100 && !(m_active && m_k == 1); i++) drive(0, 0, 1'($urandom_range(0, 1)), 0);
        rst = 1'b0;
        drive(0, 0, 1, 0);
        chk("s6_rst_running", 64'(running_o),  64'd0);
        chk("s6_rst_en",      64'(chain_en_o), 64'd0);
        chk("s6_rst_data",    64'(data_o),     64'd0);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        chk("s6_no_pulses", 64'(n_done + n_abort), 64'd0);
        clear_counts();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 300 && n_done == 0; i++) drive(0, 0, 1'($urandom_range(0, 1)), 0);
        drive(0, 0, 0, 0);
        chk("s6_flush_cycles", 64'(n_flush), 64'd4);
        chk("s6_valid_count",  64'(n_valid), 64'd3);
        chk("s6_done_count",   64'(n_done),  64'd1);

        // Random traffic: starts, aborts, backpressure, occasional reset
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 150; i++) begin
                s = ($urandom_range(0, 9) == 0);
                a = ($urandom_range(0, 99) == 0);
                v = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 3) == 0);
                capture_len_i = 16'($urandom_range(0, 10));
                rst = ($urandom_range(0, 299) != 0);
                drive(s, a, v, b);
            end
            rst = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
